// File: rtl/game_flow_controller.sv
// Round/match sequencer for a two-tank game: menu, round setup, pre-round hold, play and
// game-over display, with per-player round scores and winner reporting.
module game_flow_controller #(
  parameter logic [7:0] READY_FRAMES    = 8'd120,
  parameter logic [7:0] GAMEOVER_FRAMES = 8'd180,
  parameter logic [3:0] WIN_SCORE       = 4'd3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       tank1_alive,
  input  logic       tank2_alive,
  output logic [2:0] state_o,
  output logic       game_reset,
  output logic       play_en,
  output logic       show_gameover,
  output logic [1:0] winner,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [7:0] frames_left
);

  typedef enum logic [2:0] {
    StMenu  = 3'd0,
    StSetup = 3'd1,
    StReady = 3'd2,
    StPlay  = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       frame_prev_q, start_prev_q;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] frames_q, frames_d;

  logic frame_tick, start_edge, match_done;

  assign frame_tick = frame_clk & ~frame_prev_q;
  assign start_edge = start_key & ~start_prev_q;
  assign match_done = (score1_q >= WIN_SCORE) || (score2_q >= WIN_SCORE);

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    frames_d = frames_q;
    case (state_q)
      StMenu: begin
        if (start_edge) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        frames_d = READY_FRAMES;
        state_d  = StReady;
      end
      StReady: begin
        if (frames_q == 8'd0) begin
          state_d = StPlay;
        end else if (frame_tick) begin
          frames_d = frames_q - 8'd1;
        end
      end
      StPlay: begin
        // A death overrides any frame tick arriving in the same cycle.
        if (!tank1_alive || !tank2_alive) begin
          frames_d = GAMEOVER_FRAMES;
          state_d  = StOver;
          if (!tank1_alive && !tank2_alive) begin
            winner_d = 2'b11;
          end else if (!tank1_alive) begin
            winner_d = 2'b10;
            if (score2_q != 4'hF) score2_d = score2_q + 4'd1;
          end else begin
            winner_d = 2'b01;
            if (score1_q != 4'hF) score1_d = score1_q + 4'd1;
          end
        end
      end
      StOver: begin
        if ((frames_q == 8'd0) || start_edge) begin
          state_d = match_done ? StMenu : StSetup;
        end else if (frame_tick) begin
          frames_d = frames_q - 8'd1;
        end
      end
      default: state_d = StMenu;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StMenu;
      frame_prev_q <= 1'b0;
      start_prev_q <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
      frames_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_clk;
      start_prev_q <= start_key;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      frames_q     <= frames_d;
    end
  end

  assign state_o       = state_q;
  assign game_reset    = (state_q == StSetup);
  assign play_en       = (state_q == StPlay);
  assign show_gameover = (state_q == StOver);
  assign winner        = winner_q;
  assign score1        = score1_q;
  assign score2        = score2_q;
  assign frames_left   = frames_q;

endmodule
